store_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one negedge-capturing 32-bit neuron state store between N_REQ requesters (e.g. neuron update units).
- Selects one requester, drives its data into the store's input, reads back the stored value, acknowledges, then rotates priority.
- Sits between the neuron update logic and the shared store; the store has no write enable and captures its input on every falling edge, so this block owns and holds the store input.

---
 rtl/store_rr_arbiter.sv | 118 +++++++++++
 tb/tb_store_rr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_rr_arbiter.sv
// Round-robin arbiter in front of a shared negedge-capturing state store.
// One requester at a time gets its word driven onto store_din, the stored
// value is read back one cycle later and returned with an ack pulse, and
// priority then rotates past the winner.
// Optional build: define STORE_ARB_FIXED_PRIO_EN for fixed priority
// (lowest set req index wins, the priority pointer stays at 0).
module store_rr_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [DATA_W-1:0]         store_din,
  input  logic [DATA_W-1:0]         store_dout,
  output logic                      store_we,
  output logic                      busy
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(N_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StAck
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   win_q;

  logic [PtrW-1:0]   win_idx;
  logic              win_found;
  logic [PtrW-1:0]   cand_idx;
  int unsigned       cand;

  // Winner search: first set req bit starting at ptr, wrapping explicitly
  // so that non-power-of-two N_REQ never indexes past the last requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = PtrW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Transaction FSM with registered outputs; store_din only moves on entry
  // to WRITE (or reset) so the store keeps re-capturing the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      grant     <= '0;
      ack       <= '0;
      rdata     <= '0;
      store_din <= '0;
      store_we  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            win_q          <= win_idx;
            grant          <= '0;
            grant[win_idx] <= 1'b1;
            store_din      <= req_data[32'(win_idx)*DATA_W +: DATA_W];
            store_we       <= 1'b1;
            busy           <= 1'b1;
            state_q        <= StWrite;
          end
        end
        StWrite: begin
          // The store captured store_din on the falling edge of this cycle.
          rdata      <= store_dout;
          ack        <= '0;
          ack[win_q] <= 1'b1;
          store_we   <= 1'b0;
          state_q    <= StAck;
        end
        StAck: begin
          ack   <= '0;
          grant <= '0;
          busy  <= 1'b0;
`ifdef STORE_ARB_FIXED_PRIO_EN
          ptr_q <= '0;
`else
          if (win_q == PtrMax) begin
            ptr_q <= '0;
          end else begin
            ptr_q <= win_q + 1'b1;
          end
`endif
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rr_arbiter.sv
// Self-checking bench for store_rr_arbiter: directed transaction table,
// hand-written corner sequences, then randomized stimulus against a
// cycle-level reference model of the arbitration rules.
module tb_store_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic [W-1:0]     rdata;
  logic [W-1:0]     store_din;
  logic [W-1:0]     store_dout;
  logic             store_we;
  logic             busy;

  int errs;
  int checks;

  store_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .ack       (ack),
    .rdata     (rdata),
    .store_din (store_din),
    .store_dout(store_dout),
    .store_we  (store_we),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The shared store: no write enable, captures on every falling edge.
  always @(negedge clk) store_dout <= store_din;

  // Reference model state: phase 0 idle, 1 write, 2 ack.
  int           m_phase;
  int           m_ptr;
  int           m_win;
  logic [N-1:0] m_grant;
  logic [N-1:0] m_ack;
  logic [W-1:0] m_din;
  logic [W-1:0] m_rdata;
  logic         m_we;
  logic         m_busy;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
    if (r) begin
      m_phase = 0; m_ptr = 0; m_win = 0;
      m_grant = '0; m_ack = '0; m_din = '0; m_rdata = '0; m_we = 1'b0; m_busy = 1'b0;
    end else if (m_phase == 0) begin
      if (q != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (q[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        end
        m_grant = N'(1 << m_win);
        m_din   = d[m_win*W +: W];
        m_we    = 1'b1;
        m_busy  = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_rdata = m_din;
      m_ack   = N'(1 << m_win);
      m_we    = 1'b0;
      m_phase = 2;
    end else begin
      m_ack   = '0;
      m_grant = '0;
      m_busy  = 1'b0;
`ifndef STORE_ARB_FIXED_PRIO_EN
      m_ptr   = (m_win + 1) % N;
`endif
      m_phase = 0;
    end
  endtask

  // One rising edge with the current inputs; compare everything to the model.
  task automatic tick();
    model_edge(rst, req, req_data);
    @(posedge clk);
    #1;
    chk("m_grant", W'(grant), W'(m_grant));
    chk("m_ack", W'(ack), W'(m_ack));
    chk("m_rdata", rdata, m_rdata);
    chk("m_store_din", store_din, m_din);
    chk("m_store_we", W'(store_we), W'(m_we));
    chk("m_busy", W'(busy), W'(m_busy));
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] e);
    return {e, c, b, a};
  endfunction

  // Full 3-cycle transaction with explicit expectations for winner w.
  task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] d, input int w,
                     input bit drop);
    logic [W-1:0] dw;
    dw       = d[w*W +: W];
    req      = r;
    req_data = d;
    tick();
    chk("grant_k", W'(grant), W'(1 << w));
    chk("din_k", store_din, dw);
    chk("we_k", W'(store_we), 1);
    chk("busy_k", W'(busy), 1);
    if (drop) req[w] = 1'b0;
    tick();
    chk("ack_k1", W'(ack), W'(1 << w));
    chk("rdata_k1", rdata, dw);
    chk("we_k1", W'(store_we), 0);
    tick();
    chk("ack_k2", W'(ack), 0);
    chk("grant_k2", W'(grant), 0);
    chk("busy_k2", W'(busy), 0);
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    int           rr_win;
    int           fix_win;
  } vec_t;

  vec_t tv[10];

  initial begin
    int ew;
    errs   = 0;
    checks = 0;

    tv[0] = '{4'b0100, 32'd0, 32'd0, 32'd5, 32'd0, 2, 2};
    tv[1] = '{4'b1111, 32'd1, 32'd8, 32'd9, 32'd3, 3, 0};
    tv[2] = '{4'b1111, 32'd1, 32'd8, 32'd9, 32'd3, 0, 0};
    tv[3] = '{4'b1111, 32'd1, 32'd8, 32'd9, 32'd3, 1, 0};
    tv[4] = '{4'b1111, 32'd1, 32'd8, 32'd9, 32'd3, 2, 0};
    tv[5] = '{4'b1111, 32'd1, 32'd8, 32'd9, 32'd3, 3, 0};
    tv[6] = '{4'b1001, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0};
    tv[7] = '{4'b0010, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 1, 1};
    tv[8] = '{4'b1001, 32'hC0, 32'hC1, 32'hC2, 32'hDEADBEEF, 3, 0};
    tv[9] = '{4'b0110, 32'hD0, 32'h12345678, 32'hD2, 32'hD3, 1, 1};

    // Reset held two cycles with all requests pending.
    rst      = 1'b1;
    req      = 4'b1111;
    req_data = pack4(32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_grant", W'(grant), 0);
      chk("rst_ack", W'(ack), 0);
      chk("rst_din", store_din, 0);
      chk("rst_we", W'(store_we), 0);
      chk("rst_busy", W'(busy), 0);
    end
    rst = 1'b0;
    req = '0;
    tick();
    chk("idle_busy", W'(busy), 0);

    // Directed table: single request, full contention, wrap and skip.
    for (int i = 0; i < 10; i++) begin
`ifdef STORE_ARB_FIXED_PRIO_EN
      ew = tv[i].fix_win;
`else
      ew = tv[i].rr_win;
`endif
      txn(tv[i].r, pack4(tv[i].d0, tv[i].d1, tv[i].d2, tv[i].d3), ew, 1'b0);
    end

    // Winner drops req during WRITE; ack still completes, ptr still moves.
    txn(4'b0100, pack4(32'h0, 32'h0, 32'h77, 32'h0), 2, 1'b1);
`ifdef STORE_ARB_FIXED_PRIO_EN
    txn(4'b1111, pack4(32'h10, 32'h11, 32'h12, 32'h13), 0, 1'b0);
    txn(4'b1111, pack4(32'h20, 32'h21, 32'h22, 32'h23), 0, 1'b0);
    ew = 0;
`else
    txn(4'b1111, pack4(32'h10, 32'h11, 32'h12, 32'h13), 3, 1'b0);
    txn(4'b1111, pack4(32'h20, 32'h21, 32'h22, 32'h23), 0, 1'b0);
    ew = 1;
`endif

    // Reset during WRITE: no ack, outputs cleared, store re-captures 0.
    req      = 4'b1111;
    req_data = pack4(32'h30, 32'h31, 32'h32, 32'h33);
    tick();
    chk("mid_grant", W'(grant), W'(1 << ew));
    rst = 1'b1;
    tick();
    chk("mid_ack", W'(ack), 0);
    chk("mid_grant0", W'(grant), 0);
    chk("mid_din", store_din, 0);
    chk("mid_we", W'(store_we), 0);
    chk("mid_busy", W'(busy), 0);
    @(negedge clk);
    #1;
    chk("mid_store_dout", store_dout, 0);
    rst = 1'b0;
    txn(4'b1111, pack4(32'h40, 32'h41, 32'h42, 32'h43), 0, 1'b0);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      req      = N'($urandom);
      req_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 3; i++) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
